// File: rtl/regbank_pkg.sv
// Shared helpers and types for the multi-read-port register bank.
// Address width is derived from the register count everywhere.
package regbank_pkg;

    function automatic int addr_w(input int nregs);
        return $clog2(nregs);
    endfunction

    localparam int RB_DEF_NREGS = 32;
    localparam int RB_DEF_AW    = addr_w(RB_DEF_NREGS);

    typedef logic [RB_DEF_AW-1:0] rb_addr_t;

    localparam rb_addr_t RB_ZERO_ADDR = '0;

endpackage

// File: rtl/regbank_rdport.sv
// One read port: register mux, r0 masking, same-cycle writeback forwarding
// and busy reporting for the addressed register.
module regbank_rdport
    import regbank_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    parameter int AW     = addr_w(NREGS)
) (
    input  logic [AW-1:0]         rd_addr,
    input  logic [NREGS*XLEN-1:0] regs_flat,
    input  logic [NREGS-1:0]      busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    output logic [XLEN-1:0]       rd_data,
    output logic                  rd_busy
);

    logic is_zero;
    logic fwd;

    assign is_zero = (rd_addr == AW'(RB_ZERO_ADDR));
    assign fwd     = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);

    always_comb begin
        rd_data = regs_flat[int'(rd_addr)*XLEN +: XLEN];
        rd_busy = busy[rd_addr];
        if (is_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (fwd) begin
            // the pending writeback already satisfies the reader
            rd_data = wr_data;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regbank_mp_scb.sv
// Multi-read-port register bank with per-register busy scoreboard,
// reservation handshake and optional write->read forwarding.
module regbank_mp_scb
    import regbank_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = addr_w(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ack,
    output logic [AW-1:0]       busy_cnt
);

    logic [NREGS*XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]      busy_q, busy_d;
    logic [AW-1:0]         busy_cnt_q, busy_cnt_d;

    logic             wr_hit;
    logic             rsv_set;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [NREGS-1:0] wr_dec;
    logic [NREGS-1:0] rsv_dec;

    always_comb begin
        wr_hit  = wr_en && (wr_addr != AW'(RB_ZERO_ADDR));
        // a busy register may be re-reserved only while its producer writes back
        rsv_ack = rsv_en && ((rsv_addr == AW'(RB_ZERO_ADDR)) || !busy_q[rsv_addr]
                             || (wr_en && (wr_addr == rsv_addr)));
        rsv_set = rsv_ack && (rsv_addr != AW'(RB_ZERO_ADDR));

        wr_dec  = wr_hit  ? (NREGS'(1) << wr_addr)  : '0;
        rsv_dec = rsv_set ? (NREGS'(1) << rsv_addr) : '0;
        busy_d  = (busy_q & ~wr_dec) | rsv_dec;

        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[int'(wr_addr)*XLEN +: XLEN] = wr_data;
        end

        cnt_inc    = rsv_set && !busy_q[rsv_addr];
        cnt_dec    = wr_hit && busy_q[wr_addr] && !(rsv_set && (rsv_addr == wr_addr));
        busy_cnt_d = busy_cnt_q + AW'(cnt_inc) - AW'(cnt_dec);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q     <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rdport
        regbank_rdport #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .BYPASS (BYPASS),
            .AW     (AW)
        ) u_rdport (
            .rd_addr   (rd_addr[p*AW +: AW]),
            .regs_flat (regs_q),
            .busy      (busy_q),
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .rd_data   (rd_data[p*XLEN +: XLEN]),
            .rd_busy   (rd_busy[p])
        );
    end

endmodule

// File: tb/tb_regbank_mp_scb.sv
// Bench for regbank_mp_scb: forwarding and non-forwarding instances share
// stimulus; directed table, reset/refill sequence, then random traffic.
module tb_regbank_mp_scb;
    import regbank_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic        rsv_ack, rsv_ack_nb;
    logic [4:0]  busy_cnt, busy_cnt_nb;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_reg [32];
    bit          m_busy[32];

    always #5 clk = ~clk;

    regbank_mp_scb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(rsv_ack), .busy_cnt(busy_cnt)
    );

    regbank_mp_scb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(rsv_ack_nb), .busy_cnt(busy_cnt_nb)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d0nb;
        logic [31:0] d1;
        logic        b0;
        logic        b0nb;
        logic        ack;
        logic [4:0]  cnt;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra,
                         input logic [4:0] a0, input logic [4:0] a1);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rsv_en   = re;
        rsv_addr = ra;
        rd_addr  = {a1, a0};
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic m_ack();
        return rsv_en && (rsv_addr == 5'd0 || !m_busy[rsv_addr] ||
                          (wr_en && wr_addr == rsv_addr));
    endfunction

    task automatic model_edge();
        logic ack;
        ack = m_ack();
        if (wr_en && wr_addr != 5'd0) begin
            m_reg[wr_addr]  = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (ack && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    endtask

    task automatic check_model();
        logic [4:0]  a;
        logic        hit;
        logic [31:0] ed, ednb;
        logic        eb, ebnb;
        for (int p = 0; p < 2; p++) begin
            a    = rd_addr[p*5 +: 5];
            hit  = wr_en && (wr_addr == a) && (a != 5'd0);
            ed   = (a == 5'd0) ? 32'd0 : (hit ? wr_data : m_reg[a]);
            ednb = (a == 5'd0) ? 32'd0 : m_reg[a];
            eb   = (a == 5'd0 || hit) ? 1'b0 : m_busy[a];
            ebnb = (a == 5'd0) ? 1'b0 : m_busy[a];
            chk($sformatf("rd_data[%0d]", p),    rd_data[p*32 +: 32],    ed);
            chk($sformatf("rd_data_nb[%0d]", p), rd_data_nb[p*32 +: 32], ednb);
            chk($sformatf("rd_busy[%0d]", p),    32'(rd_busy[p]),        32'(eb));
            chk($sformatf("rd_busy_nb[%0d]", p), 32'(rd_busy_nb[p]),     32'(ebnb));
        end
        chk("rsv_ack",     32'(rsv_ack),     32'(m_ack()));
        chk("rsv_ack_nb",  32'(rsv_ack_nb),  32'(m_ack()));
        chk("busy_cnt",    32'(busy_cnt),    32'(m_cnt()));
        chk("busy_cnt_nb", 32'(busy_cnt_nb), 32'(m_cnt()));
    endtask

    initial begin
        tbl[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0,  5'd31, 32'h0,        32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0};
        tbl[0].a0 = 5'd5;
        tbl[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'h0,  32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7,  5'd5,  32'h0,        32'h0,  32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 5'd0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7,  5'd5,  32'h0,        32'h0,  32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 5'd1};
        tbl[5]  = '{1'b1, 5'd7, 32'h11,       1'b0, 5'd0, 5'd7,  5'd5,  32'h11,       32'h0,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 5'd1};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7,  5'd5,  32'h11,       32'h11, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7,  5'd5,  32'h11,       32'h11, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 5'd0};
        tbl[8]  = '{1'b1, 5'd7, 32'h22,       1'b1, 5'd7, 5'd7,  5'd5,  32'h22,       32'h11, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 5'd1};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7,  5'd5,  32'h22,       32'h22, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 5'd1};
        tbl[10] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0,  5'd5,  32'h0,        32'h0,  32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 5'd1};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd1};

        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // every address on every port reads zero after reset
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(a), 5'(31 - a));
            #1;
            chk("rst_rd0",    rd_data[31:0],     32'd0);
            chk("rst_rd1",    rd_data[63:32],    32'd0);
            chk("rst_rd0_nb", rd_data_nb[31:0],  32'd0);
            chk("rst_busy",   32'(rd_busy),      32'd0);
            chk("rst_cnt",    32'(busy_cnt),     32'd0);
        end

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].a0, tbl[i].a1);
            #1;
            chk($sformatf("tbl%0d_d0", i),   rd_data[31:0],         tbl[i].d0);
            chk($sformatf("tbl%0d_d0nb", i), rd_data_nb[31:0],      tbl[i].d0nb);
            chk($sformatf("tbl%0d_d1", i),   rd_data[63:32],        tbl[i].d1);
            chk($sformatf("tbl%0d_b0", i),   32'(rd_busy[0]),       32'(tbl[i].b0));
            chk($sformatf("tbl%0d_b0nb", i), 32'(rd_busy_nb[0]),    32'(tbl[i].b0nb));
            chk($sformatf("tbl%0d_ack", i),  32'(rsv_ack),          32'(tbl[i].ack));
            chk($sformatf("tbl%0d_ackn", i), 32'(rsv_ack_nb),       32'(tbl[i].ack));
            chk($sformatf("tbl%0d_cnt", i),  32'(busy_cnt),         32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_cntn", i), 32'(busy_cnt_nb),      32'(tbl[i].cnt));
            @(posedge clk);
            model_edge();
        end

        // fill the scoreboard, then drop reset part-way through
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 5'd1, 5'd2);
            #1;
            check_model();
            if (a == 16) begin
                reset = 1'b0;
                #1;
                chk("async_rst_cnt",    32'(busy_cnt),    32'd0);
                chk("async_rst_cnt_nb", 32'(busy_cnt_nb), 32'd0);
                chk("async_rst_busy",   32'(rd_busy),     32'd0);
                chk("async_rst_busy_nb", 32'(rd_busy_nb), 32'd0);
                chk("async_rst_r5",     rd_data[31:0],    32'd0);
                rsv_en = 1'b0;
                model_reset();
                #1;
                reset = 1'b1;
                break;
            end
            @(posedge clk);
            model_edge();
        end

        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 5'(a), 5'(32 - a));
            #1;
            check_model();
            @(posedge clk);
            model_edge();
        end

        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd31);
        #1;
        chk("full_ack", 32'(rsv_ack),  32'd0);
        chk("full_cnt", 32'(busy_cnt), 32'd31);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd31);
        #1;
        chk("full_cnt_hold", 32'(busy_cnt), 32'd31);
        check_model();
        @(posedge clk);
        model_edge();

        for (int n = 0; n < 600; n++) begin
            logic [4:0] wa, ra, a0, a1;
            @(negedge clk);
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            a0 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wa, $urandom(), 1'($urandom_range(0, 1)), ra, a0, a1);
            #1;
            check_model();
            @(posedge clk);
            model_edge();
        end

        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4);
        #1;
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
